// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: default 640x480 timing, total derivation, FSM encoding and RGB565 colour-bar palette.
package lcd_timing_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF = 33;
    localparam logic SYNC_POL_DEF = 1'b0;
    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction
    localparam int H_TOTAL_DEF = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
    typedef enum logic {SYNC_WAIT = 1'b0, RUN = 1'b1} state_e;
    // bar 0 (leftmost) is the least significant element
    localparam logic [7:0][15:0] BAR_RGB = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                            16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};
endpackage

// File: rtl/lcd_pixel_driver_if.sv
// lcd_pixel_driver_if: pixel FIFO and LCD panel signals; test_pattern exists only with LCD_PIXEL_DRIVER_TEST_PATTERN_EN.
interface lcd_pixel_driver_if;
    logic [15:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic        clear_err;
    logic        lcd_hsync;
    logic        lcd_vsync;
    logic        lcd_de;
    logic [15:0] lcd_rgb;
    logic        underflow;
    logic        frame_start;
`ifdef LCD_PIXEL_DRIVER_TEST_PATTERN_EN
    logic        test_pattern;
    modport master (output fifo_data, fifo_empty, clear_err, test_pattern,
                    input fifo_rdreq, lcd_hsync, lcd_vsync, lcd_de, lcd_rgb, underflow, frame_start);
    modport slave (input fifo_data, fifo_empty, clear_err, test_pattern,
                   output fifo_rdreq, lcd_hsync, lcd_vsync, lcd_de, lcd_rgb, underflow, frame_start);
`else
    modport master (output fifo_data, fifo_empty, clear_err,
                    input fifo_rdreq, lcd_hsync, lcd_vsync, lcd_de, lcd_rgb, underflow, frame_start);
    modport slave (input fifo_data, fifo_empty, clear_err,
                   output fifo_rdreq, lcd_hsync, lcd_vsync, lcd_de, lcd_rgb, underflow, frame_start);
`endif
endinterface

// File: rtl/lcd_timing_counter.sv
// lcd_timing_counter: free-running h/v raster counters with active-area and sync decodes.
module lcd_timing_counter import lcd_timing_pkg::*; #(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = SYNC_POL_DEF,
    parameter int   HW       = 10,
    parameter int   VW       = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          active_o,
    output logic          hsync_o,
    output logic          vsync_o
);
    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_wrap;
    always_comb begin
        h_wrap = h_q == HW'(H_TOTAL - 1);
        h_d = h_wrap ? '0 : h_q + 1'b1;
        v_d = !h_wrap ? v_q : (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end
    assign h_cnt_o  = h_q;
    assign v_cnt_o  = v_q;
    assign active_o = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    assign hsync_o  = (h_q >= HW'(H_ACTIVE + H_FP) && h_q < HW'(H_ACTIVE + H_FP + H_SYNC)) ? SYNC_POL : ~SYNC_POL;
    assign vsync_o  = (v_q >= VW'(V_ACTIVE + V_FP) && v_q < VW'(V_ACTIVE + V_FP + V_SYNC)) ? SYNC_POL : ~SYNC_POL;
endmodule

// File: rtl/lcd_pixel_driver.sv
// lcd_pixel_driver: streams RGB565 pixels from a FIFO onto an LCD raster with 2-clock aligned outputs.
// Optional colour-bar generator enabled by LCD_PIXEL_DRIVER_TEST_PATTERN_EN.
module lcd_pixel_driver import lcd_timing_pkg::*; #(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = SYNC_POL_DEF
) (
    input logic              clk,
    input logic              reset_n,
    lcd_pixel_driver_if.slave bus
);
    localparam int HW = $clog2(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW = $clog2(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active, hsync, vsync, start, run, rd, uf_d, tp;
    logic [15:0]   bar_rgb;
    state_e        state_q, state_d;
    logic          de1_q, hs1_q, vs1_q, rd1_q, fs1_q;
    logic [15:0]   pix1_q;
    logic          de_q, hs_q, vs_q, fs_q, uf_q;
    logic [15:0]   rgb_q;
    lcd_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL), .HW(HW), .VW(VW)
    ) u_timing (
        .clk(clk), .reset_n(reset_n), .h_cnt_o(h_cnt), .v_cnt_o(v_cnt),
        .active_o(active), .hsync_o(hsync), .vsync_o(vsync)
    );
`ifdef LCD_PIXEL_DRIVER_TEST_PATTERN_EN
    assign tp      = bus.test_pattern;
    assign bar_rgb = BAR_RGB[3'(h_cnt / HW'(H_ACTIVE / 8))];
`else
    assign tp      = 1'b0;
    assign bar_rgb = '0;
`endif
    assign start = (h_cnt == '0) && (v_cnt == '0) && !bus.fifo_empty;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= SYNC_WAIT;
        else          state_q <= state_d;
    end
    always_comb state_d = (state_q == SYNC_WAIT && start) ? RUN : state_q;
    // the frame-start pixel is read in the same cycle the FSM leaves SYNC_WAIT
    always_comb begin
        run  = reset_n && !tp && (state_q == RUN || start);
        rd   = run && active && !bus.fifo_empty;
        uf_d = (run && active && bus.fifo_empty) || (uf_q && !bus.clear_err);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de1_q  <= 1'b0;
            hs1_q  <= ~SYNC_POL;
            vs1_q  <= ~SYNC_POL;
            rd1_q  <= 1'b0;
            fs1_q  <= 1'b0;
            pix1_q <= '0;
            de_q   <= 1'b0;
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
            fs_q   <= 1'b0;
            rgb_q  <= '0;
            uf_q   <= 1'b0;
        end else begin
            de1_q  <= active && (run || tp);
            hs1_q  <= hsync;
            vs1_q  <= vsync;
            rd1_q  <= rd;
            fs1_q  <= run && (h_cnt == '0) && (v_cnt == '0);
            pix1_q <= (tp && active) ? bar_rgb : '0;
            de_q   <= de1_q;
            hs_q   <= hs1_q;
            vs_q   <= vs1_q;
            fs_q   <= fs1_q;
            rgb_q  <= rd1_q ? bus.fifo_data : pix1_q;
            uf_q   <= uf_d;
        end
    end
    assign bus.fifo_rdreq  = rd;
    assign bus.lcd_hsync   = hs_q;
    assign bus.lcd_vsync   = vs_q;
    assign bus.lcd_de      = de_q;
    assign bus.lcd_rgb     = rgb_q;
    assign bus.frame_start = fs_q;
    assign bus.underflow   = uf_q;
endmodule

// File: tb/tb_lcd_pixel_driver.sv
// tb_lcd_pixel_driver: raster-level reference model on a shrunken 24x13 timing plus directed literal checks.
module tb_lcd_pixel_driver;
    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 8, VFP = 1, VSW = 2, VBP = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;
    localparam logic POL = 1'b0;
    typedef struct packed {logic hs; logic vs; logic de; logic fs; logic [15:0] rgb;} exp_t;
    localparam exp_t IDLE = {~POL, ~POL, 18'h0};
    logic clk = 1'b0, reset_n = 1'b0, force_empty = 1'b0, tp_sig = 1'b0;
    int avail = 0, rd_idx = 0, n_chk = 0, n_pass = 0;
    int k = 0, m_idx = 0, cur_h = -1, cur_v = -1;
    bit m_run = 1'b0, m_uf = 1'b0;
    exp_t pipe[$];
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    lcd_pixel_driver_if bus();
    lcd_pixel_driver #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(POL)
    ) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
`ifdef LCD_PIXEL_DRIVER_TEST_PATTERN_EN
    assign bus.test_pattern = tp_sig;
`endif
    // FIFO stream: word n carries 0x1000+n, data valid the cycle after rdreq
    assign bus.fifo_empty = (rd_idx >= avail) || force_empty;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_idx <= 0;
            bus.fifo_data <= '0;
        end else if (bus.fifo_rdreq) begin
            bus.fifo_data <= 16'h1000 + 16'(rd_idx);
            rd_idx <= rd_idx + 1;
        end
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask
    always @(negedge clk) begin
        int h, v;
        bit act, emp, rd_exp;
        exp_t e, o;
        if (!reset_n) begin
            k = 0; m_run = 1'b0; m_uf = 1'b0; m_idx = 0;
            pipe.delete();
            check("reset_outs", {bus.fifo_rdreq, bus.lcd_hsync, bus.lcd_vsync, bus.lcd_de,
                                 bus.underflow, bus.frame_start, bus.lcd_rgb}, {1'b0, ~POL, ~POL, 19'h0});
        end else begin
            h = k % HT;
            v = (k / HT) % VT;
            cur_h = h;
            cur_v = v;
            act = (h < HA) && (v < VA);
            emp = bus.fifo_empty;
            if (!m_run && h == 0 && v == 0 && !emp) m_run = 1'b1;
            rd_exp = m_run && act && !emp && !tp_sig;
            check("rdreq", bus.fifo_rdreq, rd_exp);
            check("underflow", bus.underflow, m_uf);
            m_uf = (m_run && act && emp && !tp_sig) || (m_uf && !bus.clear_err);
            o = IDLE;
            if (pipe.size() == 2) o = pipe.pop_front();
            check("pixel_outs", {bus.lcd_hsync, bus.lcd_vsync, bus.lcd_de, bus.frame_start, bus.lcd_rgb}, o);
            e.hs = (h >= HA + HFP && h < HA + HFP + HSW) ? POL : ~POL;
            e.vs = (v >= VA + VFP && v < VA + VFP + VSW) ? POL : ~POL;
            e.de = act && (m_run || tp_sig);
            e.fs = m_run && !tp_sig && h == 0 && v == 0;
            e.rgb = (tp_sig && act) ? bars[h / (HA / 8)] : rd_exp ? 16'h1000 + 16'(m_idx) : 16'h0000;
            if (rd_exp) m_idx++;
            pipe.push_back(e);
            k++;
        end
    end
    task automatic wait_pos(input int h, input int v);
        bit found = 1'b0;
        for (int n = 0; n < 2 * FT && !found; n++) begin
            @(negedge clk); #1;
            found = (cur_h == h) && (cur_v == v);
        end
        if (!found) check("wait_pos", cur_h * 256 + cur_v, h * 256 + v);
    endtask
    // sel: 0 rdreq high, 1 frame_start high, 2 hsync asserted
    task automatic wait_for(input string name, input int sel, output time t);
        bit found = 1'b0;
        for (int n = 0; n < 2 * FT && !found; n++) begin
            @(negedge clk); #1;
            found = sel == 0 ? bus.fifo_rdreq : sel == 1 ? bus.frame_start : (bus.lcd_hsync == POL);
        end
        if (!found) check(name, 0, 1);
        t = $time;
    endtask
    task automatic pulse_clear();
        bus.clear_err = 1'b1;
        @(posedge clk); #1;
        bus.clear_err = 1'b0;
    endtask
`ifdef LCD_PIXEL_DRIVER_TEST_PATTERN_EN
    task automatic tp_pix(input int h, input logic [15:0] exp);
        wait_pos(h, 2);
        repeat (2) @(posedge clk);
        #1;
        check("tp_pixel", bus.lcd_rgb, exp);
        check("tp_rdreq", bus.fifo_rdreq, 1'b0);
    endtask
`endif
    initial begin
        time t0, t1, t2;
        bus.clear_err = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2 * FT + 5) @(posedge clk);
        #1 avail = 100000;
        wait_for("rdreq_start", 0, t0);
        wait_for("frame_start", 1, t1);
        check("fs_latency", 32'((t1 - t0) / 10), 2);
        check("first_pixel", {bus.lcd_de, bus.lcd_rgb}, {1'b1, 16'h1000});
        wait_for("hsync_edge", 2, t2);
        check("hsync_latency", 32'((t2 - t0) / 10), HA + HFP + 2);
        wait_pos(9, 5);
        @(posedge clk); #1 force_empty = 1'b1;
        repeat (3) @(posedge clk);
        #1 force_empty = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("uf_set", bus.underflow, 1'b1);
        pulse_clear();
        check("uf_cleared", bus.underflow, 1'b0);
        wait_pos(2, 6);
        @(posedge clk); #1 force_empty = 1'b1;
        @(posedge clk); #1 bus.clear_err = 1'b1;
        @(posedge clk); #1 force_empty = 1'b0; bus.clear_err = 1'b0;
        check("uf_clear_collision", bus.underflow, 1'b1);
        pulse_clear();
        check("uf_cleared2", bus.underflow, 1'b0);
        wait_pos(6, 3);
        @(posedge clk); #1 check("pre_reset_de", bus.lcd_de, 1'b1);
        reset_n = 1'b0;
        #1 check("async_reset", {bus.fifo_rdreq, bus.lcd_hsync, bus.lcd_vsync, bus.lcd_de, bus.frame_start,
                                 bus.underflow, bus.lcd_rgb}, {1'b0, ~POL, ~POL, 19'h0});
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (FT + 3) @(posedge clk);
`ifdef LCD_PIXEL_DRIVER_TEST_PATTERN_EN
        #1 tp_sig = 1'b1;
        tp_pix(0, 16'hFFFF);
        tp_pix(2, 16'hFFE0);
        tp_pix(15, 16'h0000);
`endif
        repeat (50) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule

// File: doc/lcd_pixel_driver.md
LCD_PIXEL_DRIVER -- requirements
Module: lcd_pixel_driver

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_ACTIVE 640 visible pixels/line; H_FP 16 front porch; H_SYNC 96 hsync width; H_BP 48 back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; SYNC_POL 0 sync active level.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 pixel clock; reset_n in 1 reset, asynchronous, active-low.
REQ-003 fifo_data in 16 RGB565 pixel from pixel FIFO (normal mode: valid the cycle after rdreq).
REQ-004 fifo_empty in 1 FIFO empty flag.
REQ-005 fifo_rdreq out 1 FIFO read request.
REQ-006 clear_err in 1 single-cycle pulse clearing underflow.
REQ-007 lcd_hsync out 1, lcd_vsync out 1, lcd_de out 1 data enable, lcd_rgb out 16 RGB565 pixel.
REQ-008 underflow out 1 sticky FIFO-starved flag; frame_start out 1 one-cycle pulse at first active pixel of each frame.

Function
REQ-009 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800), wrap to 0; v_cnt SHALL increment on h_cnt wrap, 0..V_TOTAL-1 (525), wrap to 0.
REQ-010 active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
REQ-011 hsync asserted (= SYNC_POL) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751); vsync for v_cnt in [490, 491]; otherwise ~SYNC_POL.
REQ-012 States: SYNC_WAIT, RUN; SYNC_WAIT -> RUN when h_cnt=0, v_cnt=0 and fifo_empty=0; RUN held until reset.
REQ-013 In SYNC_WAIT fifo_rdreq SHALL be 0; timing and syncs SHALL run; lcd_de=0, lcd_rgb=0.
REQ-014 In RUN fifo_rdreq = active and not fifo_empty (combinational, same cycle as counters).
REQ-015 lcd_hsync, lcd_vsync, lcd_de SHALL be the counter-cycle decodes delayed exactly 2 clocks; lcd_rgb SHALL be fifo_data registered on the cycle following rdreq, aligned with lcd_de.
REQ-016 Underflow: active pixel in RUN with fifo_empty=1 -> no read, lcd_rgb=0x0000 for that pixel, lcd_de still 1, underflow set.
REQ-017 underflow SHALL stay set until clear_err; clear_err coincident with a new underflow event -> underflow remains 1.
REQ-018 frame_start SHALL pulse coincident with lcd_de for h=0, v=0 in RUN only.
REQ-019 lcd_rgb SHALL be 0x0000 whenever lcd_de=0.

Reset
REQ-020 reset_n low SHALL asynchronously force: h_cnt=v_cnt=0, state SYNC_WAIT, pipeline cleared, fifo_rdreq=0, lcd_de=0, lcd_rgb=0, lcd_hsync=lcd_vsync=~SYNC_POL, underflow=0, frame_start=0.
REQ-021 Reset mid-frame SHALL abandon the frame; after release, first RUN frame starts only at next (0,0) with FIFO non-empty; FIFO flushing is the FIFO owner's duty.

Configuration
REQ-022 Macro LCD_PIXEL_DRIVER_TEST_PATTERN_EN defined: adds input test_pattern 1; when 1, fifo_rdreq=0, underflow not set, lcd_rgb = 8 vertical colour bars of H_ACTIVE/8 px (white, yellow, cyan, green, magenta, red, blue, black in RGB565), state machine bypassed (de follows active).
REQ-023 Macro undefined: no test_pattern port, no bar logic.

Structure
REQ-024 Package lcd_timing_pkg SHALL hold default timing constants, H_TOTAL/V_TOTAL derivation, state encoding, colour-bar RGB565 constants.
REQ-025 Sub-module lcd_timing_counter SHALL own h_cnt/v_cnt, active, hsync/vsync decode; lcd_pixel_driver owns state, FIFO read, pipeline, flags.

Verification
REQ-026 Reset release, fifo_empty=1 for 2 frames -> syncs toggle with period 800/420000 clocks, rdreq never 1, lcd_de=0.
REQ-027 FIFO model pre-filled with 307200 words value=index%640 -> first frame lcd_rgb on each line runs 0..639, 480 lines, frame_start once, underflow=0.
REQ-028 fifo_empty forced 1 for pixels 100..109 of line 5 -> those pixels 0x0000 with lcd_de=1, underflow=1 until clear_err pulse, then 0.
REQ-029 reset_n asserted at h=300, v=200 in RUN -> outputs at reset values same cycle; after release no rdreq before next (0,0).
REQ-030 Check latency: rdreq at (h=0,v=0) -> lcd_de and frame_start rise exactly 2 clocks later, hsync edge 658 clocks after line start.
REQ-031 With LCD_PIXEL_DRIVER_TEST_PATTERN_EN, test_pattern=1 -> pixel 0 = 0xFFFF, pixel 80 = 0xFFE0, pixel 639 = 0x0000, rdreq=0.
